ila_dump_ctrl: RTL and testbench
================================

// Module: ila_dump_ctrl
// PURPOSE
//  Readout sequencer for the ILA sample buffer in the system-clock domain. On start, it walks
//  buffer index 0..n_samples-1 and, for each index, every value_select part 0..N_PARTS-1. It
//  drives the core's index/value_select, absorbs the core's 2-cycle read latency, and emits the
//  sampled words as a valid/ready stream with a last flag. It sits between ila_core and a
//  DMA/CPU-side stream consumer.
// PARAMETERS
//  DATA_W    32  width of value_i / m_data_o
//  BUFFER_W  10  width of index_o and n_samples_i
//  SEL_W      1  width of value_select_o (>=1)
//  N_PARTS    2  DATA_W words per sample, 1..2**SEL_W
//  DEPTH      4  output FIFO depth (power of 2, >= RD_LAT+2)
// PORTS
//  clk_i           in   1         system clock
//  cke_i           in   1         clock enable; low freezes all state, outputs hold
//  arst_i          in   1         asynchronous reset, active high
//  start_i         in   1         pulse; begin dump (ignored while busy_o)
//  abort_i         in   1         pulse; cancel dump, flush pipeline and FIFO
//  n_samples_i     in   BUFFER_W  sample count, latched on accepted start
//  index_o         out  BUFFER_W  buffer read index to core
//  value_select_o  out  SEL_W     part select to core
//  value_i         in   DATA_W    core read data, valid RD_LAT=2 cycles after index/select
//  m_valid_o       out  1         stream word valid
//  m_data_o        out  DATA_W    stream word
//  m_last_o        out  1         final word of dump (qualified by m_valid_o)
//  m_ready_i       in   1         consumer accepts word when m_valid_o&m_ready_i
//  busy_o          out  1         dump in progress
//  done_o          out  1         1-cycle pulse, dump completed (not on abort)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; FIFO empty; read pipeline cleared.
//  - FSM IDLE -> ISSUE on start_i with n_samples_i!=0: latch count, idx=0, sel=0, busy_o=1
//    on the next cycle. start_i with n_samples_i==0: done_o pulses next cycle, stay IDLE.
//  - ISSUE: issue a read in any cycle where occ < DEPTH, with occ = FIFO count + reads in
//    flight (0..RD_LAT). An issue drives index_o/value_select_o = (idx,sel); sel++, and on
//    sel==N_PARTS-1, sel wraps to 0 and idx++. The final read (idx==n-1, sel==N_PARTS-1)
//    goes to DRAIN and is tagged last. index_o/value_select_o hold their value between issues.
//  - Read pipeline: RD_LAT-stage shift of {valid,last}; at stage RD_LAT, value_i and last are
//    pushed into the FIFO. The credit rule guarantees no push into a full FIFO.
//  - DRAIN -> IDLE when no reads are in flight and the FIFO is empty after the pop of the
//    last word. In that cycle done_o=1 and busy_o falls.
//  - Stream: m_valid_o = FIFO not empty; m_data_o/m_last_o = FIFO head. Data is stable while
//    valid & !ready. With m_ready_i held high: first word valid 3 cycles after the start
//    cycle, then 1 word/cycle sustained, no bubbles.
//  - abort_i (any state): next cycle IDLE, FIFO and pipeline flushed, m_valid_o=0, busy_o=0,
//    no done_o. abort_i has priority over a simultaneous start_i. A new start is accepted in
//    the cycle after the abort.
//  - Total words = n*N_PARTS. Exactly one word carries m_last_o=1. There is no duplication or
//    loss under any m_ready_i pattern.
//  - Counters: idx is BUFFER_W bits; n max = 2**BUFFER_W-1, so idx never wraps. occ is
//    clog2(DEPTH)+1 bits.
// STRUCTURE
//  - Add to iob_ila_conf.vh: ILA_DUMP_RD_LAT=2 and the state codes ILA_DUMP_IDLE=2'd0,
//    ILA_DUMP_ISSUE=2'd1, ILA_DUMP_DRAIN=2'd2.
//  - Sub-module ila_dump_fifo: synchronous DEPTH x (DATA_W+1) FIFO with flush, push, pop,
//    count, empty. Registers via iob_reg_r/iob_reg_re.
// TESTING
//  Bench model: value_i = {index,sel} pattern, delayed 2 cycles.
//  1. N_PARTS=2, n=3, ready=1 -> 6 words {0,0},{0,1},{1,0},{1,1},{2,0},{2,1}; last on word 6;
//     first valid at start+3; done_o one pulse; busy_o low after.
//  2. n=8, ready low for 10 cycles after word 2 -> at most DEPTH reads outstanding, index_o
//     stalls, all 16 words in order, data stable while stalled.
//  3. Random m_ready_i (50%), n=100 -> 200 words exact match; one last; one done_o.
//  4. start with n=0 -> done_o next cycle, m_valid_o never 1, busy_o stays 0.
//  5. abort at word 5 of n=10, then start n=2 -> m_valid_o 0 the next cycle, no done_o;
//     new dump yields exactly 4 words from index 0. Simultaneous start+abort -> stays IDLE.
//  6. start while busy ignored; cke_i low 5 cycles mid-dump freezes; arst_i mid-dump -> all
//     outputs 0 and IDLE.

Source files
------------

// File: rtl/ila_dump_ctrl_pkg.sv
// rtl/ila_dump_ctrl_pkg.sv - shared constants and state encoding for the ILA dump sequencer
package ila_dump_ctrl_pkg;

   localparam int ILA_DUMP_RD_LAT = 2;

   typedef enum logic [1:0] {
      ILA_DUMP_IDLE  = 2'd0,
      ILA_DUMP_ISSUE = 2'd1,
      ILA_DUMP_DRAIN = 2'd2
   } ila_dump_state_t;

   // Occupancy/count width able to hold the value depth itself.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ila_dump_fifo.sv
// rtl/ila_dump_fifo.sv - small register FIFO with flush, count and empty for the dump stream
module ila_dump_fifo
   import ila_dump_ctrl_pkg::*;
#(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        arst_i,
   input  logic                        cke_i,
   input  logic                        flush_i,
   input  logic                        push_i,
   input  logic [W-1:0]                data_i,
   input  logic                        pop_i,
   output logic [W-1:0]                data_o,
   output logic [occ_width(DEPTH)-1:0] count_o,
   output logic                        empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = occ_width(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (cke_i) begin
         if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
         end else begin
            if (push_i) begin
               mem_q[wr_q] <= data_i;
               wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
               rd_q <= rd_q + AW'(1);
            end
            case ({push_i, do_pop})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: rtl/ila_dump_ctrl.sv
// rtl/ila_dump_ctrl.sv - walks the ILA sample buffer and streams every sample part out
module ila_dump_ctrl
   import ila_dump_ctrl_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int BUFFER_W = 10,
   parameter int SEL_W    = 1,
   parameter int N_PARTS  = 2,
   parameter int DEPTH    = 4
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [BUFFER_W-1:0] n_samples_i,
   output logic [BUFFER_W-1:0] index_o,
   output logic [SEL_W-1:0]    value_select_o,
   input  logic [DATA_W-1:0]   value_i,
   output logic                m_valid_o,
   output logic [DATA_W-1:0]   m_data_o,
   output logic                m_last_o,
   input  logic                m_ready_i,
   output logic                busy_o,
   output logic                done_o
);

   localparam int CNT_W = occ_width(DEPTH);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_PARTS - 1);

   ila_dump_state_t state_q, state_d;

   logic [BUFFER_W-1:0]        n_q, n_d;
   logic [BUFFER_W-1:0]        idx_q, idx_d;
   logic [SEL_W-1:0]           sel_q, sel_d;
   logic [BUFFER_W-1:0]        index_q, index_d;
   logic [SEL_W-1:0]           vsel_q, vsel_d;
   logic                       done_q, done_d;
   logic [ILA_DUMP_RD_LAT-1:0] pipe_vld_q;
   logic [ILA_DUMP_RD_LAT-1:0] pipe_last_q;
   logic                       issue;
   logic                       issue_last;

   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] occ;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [DATA_W:0]  fifo_head;

   // Credits cover both FIFO contents and reads still travelling through the core,
   // so a returning read always finds room.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < ILA_DUMP_RD_LAT; i++) begin
         inflight = inflight + CNT_W'(pipe_vld_q[i]);
      end
   end

   assign occ       = fifo_count + inflight;
   assign fifo_push = pipe_vld_q[ILA_DUMP_RD_LAT-1] & ~abort_i;
   assign fifo_pop  = ~fifo_empty & m_ready_i;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      sel_d      = sel_q;
      index_d    = index_q;
      vsel_d     = vsel_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      if (abort_i) begin
         state_d = ILA_DUMP_IDLE;
      end else begin
         case (state_q)
            ILA_DUMP_IDLE: begin
               if (start_i) begin
                  if (n_samples_i != '0) begin
                     state_d = ILA_DUMP_ISSUE;
                     n_d     = n_samples_i;
                     idx_d   = '0;
                     sel_d   = '0;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            ILA_DUMP_ISSUE: begin
               if (occ < CNT_W'(DEPTH)) begin
                  issue   = 1'b1;
                  index_d = idx_q;
                  vsel_d  = sel_q;
                  if (sel_q == SEL_LAST) begin
                     sel_d = '0;
                     if (idx_q == n_q - BUFFER_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = ILA_DUMP_DRAIN;
                     end else begin
                        idx_d = idx_q + BUFFER_W'(1);
                     end
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end
            end
            ILA_DUMP_DRAIN: begin
               // Only the tagged final word can be the sole entry left with nothing in flight.
               if (pipe_vld_q == '0 && fifo_count == CNT_W'(1) && fifo_pop) begin
                  state_d = ILA_DUMP_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ILA_DUMP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= ILA_DUMP_IDLE;
         n_q         <= '0;
         idx_q       <= '0;
         sel_q       <= '0;
         index_q     <= '0;
         vsel_q      <= '0;
         done_q      <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
      end else if (cke_i) begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         index_q <= index_d;
         vsel_q  <= vsel_d;
         done_q  <= done_d;
         if (abort_i) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
         end else begin
            pipe_vld_q  <= {pipe_vld_q[ILA_DUMP_RD_LAT-2:0], issue};
            pipe_last_q <= {pipe_last_q[ILA_DUMP_RD_LAT-2:0], issue_last};
         end
      end
   end

   ila_dump_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .cke_i   (cke_i),
      .flush_i (abort_i),
      .push_i  (fifo_push),
      .data_i  ({pipe_last_q[ILA_DUMP_RD_LAT-1], value_i}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign index_o        = index_q;
   assign value_select_o = vsel_q;
   assign m_valid_o      = ~fifo_empty;
   assign m_data_o       = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
   assign m_last_o       = ~fifo_empty & fifo_head[DATA_W];
   assign busy_o         = (state_q != ILA_DUMP_IDLE);
   assign done_o         = done_q;

endmodule

// File: tb/tb_ila_dump_ctrl.sv
// tb/tb_ila_dump_ctrl.sv - scoreboard bench for the ILA dump sequencer
module tb_ila_dump_ctrl;

   localparam int DATA_W   = 32;
   localparam int BUFFER_W = 10;
   localparam int SEL_W    = 1;
   localparam int N_PARTS  = 2;
   localparam int DEPTH    = 4;

   logic                clk_i = 1'b0;
   logic                cke_i = 1'b1;
   logic                arst_i = 1'b1;
   logic                start_i = 1'b0;
   logic                abort_i = 1'b0;
   logic [BUFFER_W-1:0] n_samples_i = '0;
   logic [BUFFER_W-1:0] index_o;
   logic [SEL_W-1:0]    value_select_o;
   logic [DATA_W-1:0]   value_i;
   logic                m_valid_o;
   logic [DATA_W-1:0]   m_data_o;
   logic                m_last_o;
   logic                m_ready_i = 1'b1;
   logic                busy_o;
   logic                done_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int words_seen = 0;
   int last_cnt = 0;
   int done_cnt = 0;
   int valid_seen = 0;
   int first_valid_cyc = 0;
   int last_cyc = 0;
   int start_cyc = 0;
   logic            stall_q = 1'b0;
   logic [DATA_W:0] stall_word = '0;
   logic [DATA_W:0] exp_q[$];

   ila_dump_ctrl #(
      .DATA_W   (DATA_W),
      .BUFFER_W (BUFFER_W),
      .SEL_W    (SEL_W),
      .N_PARTS  (N_PARTS),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .cke_i          (cke_i),
      .arst_i         (arst_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .n_samples_i    (n_samples_i),
      .index_o        (index_o),
      .value_select_o (value_select_o),
      .value_i        (value_i),
      .m_valid_o      (m_valid_o),
      .m_data_o       (m_data_o),
      .m_last_o       (m_last_o),
      .m_ready_i      (m_ready_i),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] pat(input int idx, input int sel);
      return (DATA_W'(idx) << SEL_W) | DATA_W'(sel);
   endfunction

   // Core model: data for a read arrives two cycles after the read is issued.
   always @(posedge clk_i or posedge arst_i) begin
      if (arst_i) value_i <= '0;
      else if (cke_i) value_i <= pat(int'(index_o), int'(value_select_o));
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clk_i) begin
      if (arst_i) begin
         stall_q = 1'b0;
      end else if (cke_i) begin
         if (m_valid_o && valid_seen == 0) first_valid_cyc = cyc;
         if (m_valid_o) valid_seen++;
         if (done_o) done_cnt++;
         if (stall_q) begin
            check("stall_valid", 64'(m_valid_o), 64'd1);
            check("stall_data", 64'({m_last_o, m_data_o}), 64'(stall_word));
         end
         if (m_valid_o && m_ready_i) begin
            words_seen++;
            if (m_last_o) begin
               last_cnt++;
               last_cyc = cyc;
            end
            if (exp_q.size() == 0) check("extra_word", 64'({m_last_o, m_data_o}), 64'h1_dead_beef);
            else check("word", 64'({m_last_o, m_data_o}), 64'(exp_q.pop_front()));
         end
         stall_q    = m_valid_o && !m_ready_i && !abort_i;
         stall_word = {m_last_o, m_data_o};
      end
   end

   task automatic clr_stats();
      words_seen = 0;
      last_cnt   = 0;
      done_cnt   = 0;
      valid_seen = 0;
   endtask

   // All drive tasks start and end one time unit after a rising edge.
   task automatic run_start(input int n);
      start_i     = 1'b1;
      n_samples_i = BUFFER_W'(n);
      for (int i = 0; i < n; i++) begin
         for (int s = 0; s < N_PARTS; s++) begin
            exp_q.push_back({(i == n - 1 && s == N_PARTS - 1), pat(i, s)});
         end
      end
      @(posedge clk_i); #1;
      start_i   = 1'b0;
      start_cyc = cyc;
      if (n != 0) check("busy_rise", 64'(busy_o), 64'd1);
   endtask

   task automatic wait_words(input int k, input int budget);
      int t = 0;
      while (words_seen < k && t < budget) begin
         @(posedge clk_i); #1;
         t++;
      end
      check("words_timeout", 64'(words_seen >= k), 64'd1);
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      int  t = 0;
      bit  ok = 1'b0;
      while (t < budget) begin
         if (rnd) m_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
         t++;
         if (!busy_o && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      m_ready_i = 1'b1;
      check("idle_timeout", 64'(ok), 64'd1);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] snap;
      int          ordinal;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("reset_out", 64'({m_valid_o, m_last_o, busy_o, done_o, index_o, value_select_o}), 64'd0);
      check("reset_data", 64'(m_data_o), 64'd0);
      @(posedge clk_i); #1;
      arst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;

      // 1: basic dump, latency and back-to-back streaming
      clr_stats();
      run_start(3);
      wait_idle(200, 1'b0);
      check("t1_words", 64'(words_seen), 64'd6);
      check("t1_last", 64'(last_cnt), 64'd1);
      check("t1_done", 64'(done_cnt), 64'd1);
      check("t1_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
      check("t1_burst", 64'(last_cyc - first_valid_cyc), 64'd5);
      check("t1_busy_low", 64'(busy_o), 64'd0);

      // 2: consumer stall, credits saturate at DEPTH
      clr_stats();
      run_start(8);
      wait_words(2, 100);
      m_ready_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      ordinal = int'(index_o) * N_PARTS + int'(value_select_o) + 1;
      check("t2_outstanding", 64'(ordinal - words_seen), 64'(DEPTH));
      m_ready_i = 1'b1;
      wait_idle(300, 1'b0);
      check("t2_words", 64'(words_seen), 64'd16);
      check("t2_last", 64'(last_cnt), 64'd1);
      check("t2_done", 64'(done_cnt), 64'd1);

      // 3: random backpressure
      clr_stats();
      run_start(100);
      wait_idle(3000, 1'b1);
      check("t3_words", 64'(words_seen), 64'd200);
      check("t3_last", 64'(last_cnt), 64'd1);
      check("t3_done", 64'(done_cnt), 64'd1);

      // 4: zero-length dump
      clr_stats();
      run_start(0);
      check("t4_done_pulse", 64'({done_o, busy_o}), 64'b10);
      repeat (6) @(posedge clk_i);
      #1;
      check("t4_done_cnt", 64'(done_cnt), 64'd1);
      check("t4_no_valid", 64'(valid_seen), 64'd0);
      check("t4_busy", 64'(busy_o), 64'd0);

      // 5: abort mid-dump, immediate restart, then start+abort together
      clr_stats();
      run_start(10);
      wait_words(5, 100);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      exp_q.delete();
      check("t5_abort_out", 64'({m_valid_o, busy_o}), 64'd0);
      clr_stats();
      run_start(2);
      wait_idle(200, 1'b0);
      check("t5_words", 64'(words_seen), 64'd4);
      check("t5_done", 64'(done_cnt), 64'd1);
      clr_stats();
      start_i     = 1'b1;
      abort_i     = 1'b1;
      n_samples_i = BUFFER_W'(5);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      repeat (8) @(posedge clk_i);
      #1;
      check("t5_sim_busy", 64'(busy_o), 64'd0);
      check("t5_sim_quiet", 64'(valid_seen + done_cnt), 64'd0);

      // 6: start while busy, clock-enable freeze, reset mid-dump
      clr_stats();
      run_start(6);
      repeat (2) @(posedge clk_i);
      #1;
      start_i     = 1'b1;
      n_samples_i = BUFFER_W'(3);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_words(4, 100);
      cke_i = 1'b0;
      snap  = 64'({index_o, value_select_o, m_valid_o, busy_o, m_data_o});
      repeat (5) @(posedge clk_i);
      #1;
      check("t6_cke_hold", 64'({index_o, value_select_o, m_valid_o, busy_o, m_data_o}), snap);
      cke_i = 1'b1;
      wait_idle(200, 1'b0);
      check("t6_words", 64'(words_seen), 64'd12);
      check("t6_done", 64'(done_cnt), 64'd1);
      clr_stats();
      run_start(10);
      wait_words(3, 100);
      arst_i = 1'b1;
      #1;
      check("t6_arst_out", 64'({m_valid_o, m_last_o, busy_o, done_o, index_o, value_select_o}), 64'd0);
      check("t6_arst_data", 64'(m_data_o), 64'd0);
      @(posedge clk_i); #1;
      arst_i = 1'b0;
      exp_q.delete();
      clr_stats();
      run_start(1);
      wait_idle(100, 1'b0);
      check("t6_after_rst", 64'(words_seen), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
